// File: rtl/shape_aabb_engine_if.sv
// shape_aabb_engine_if: job request / AABB result bus between fetch stage and broad-phase sort.
interface shape_aabb_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] lz;
    logic [31:0] radius;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [31:0] r_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aabb0;
    logic [31:0] aabb1;
    logic [31:0] aabb2;
    logic [31:0] aabb3;
    logic [31:0] aabb4;
    logic [31:0] aabb5;
    logic        invalid;
    modport slave (
        input  in_valid, mode, x, y, z, lz, radius, r_x, r_y, r_z, out_ready,
        output in_ready, out_valid, aabb0, aabb1, aabb2, aabb3, aabb4, aabb5, invalid
    );
    modport master (
        output in_valid, mode, x, y, z, lz, radius, r_x, r_y, r_z, out_ready,
        input  in_ready, out_valid, aabb0, aabb1, aabb2, aabb3, aabb4, aabb5, invalid
    );
endinterface

// File: rtl/shape_aabb_engine.sv
// shape_aabb_engine: sequential capsule/sphere AABB generator sharing one fp multiplier and one fp adder.
module fp_unit #(
    parameter bit ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        a_stb,
    output logic        a_ack,
    input  logic [31:0] b,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    typedef enum logic [1:0] {GET, CALC, PUT} st_t;
    st_t st, st_n;
    logic [31:0] ra, rb;

    // Denormal operands and underflowing results are flushed to signed zero; rounding is nearest-even.
    function automatic logic [31:0] fmul(input logic [31:0] p, input logic [31:0] q);
        logic s, g, sk, nan, inf, zer;
        logic [47:0] pr;
        logic [9:0] e;
        logic [22:0] m;
        logic [23:0] mr;
        s   = p[31] ^ q[31];
        zer = p[30:23] == 8'h00 || q[30:23] == 8'h00;
        inf = p[30:23] == 8'hFF || q[30:23] == 8'hFF;
        nan = (p[30:23] == 8'hFF && p[22:0] != 0) || (q[30:23] == 8'hFF && q[22:0] != 0) || (inf && zer);
        pr  = {24'd0, 1'b1, p[22:0]} * {24'd0, 1'b1, q[22:0]};
        e   = {2'b0, p[30:23]} + {2'b0, q[30:23]} - 10'd127 + {9'd0, pr[47]};
        m   = pr[47] ? pr[46:24] : pr[45:23];
        g   = pr[47] ? pr[23] : pr[22];
        sk  = pr[47] ? |pr[22:0] : |pr[21:0];
        mr  = {1'b0, m} + {23'd0, g & (sk | m[0])};
        e   = e + {9'd0, mr[23]};
        return nan ? 32'h7FC00000 : inf ? {s, 8'hFF, 23'd0} : zer ? {s, 31'd0} :
               (e[9] || e == 10'd0) ? {s, 31'd0} : (e >= 10'd255) ? {s, 8'hFF, 23'd0} : {s, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] u, v;
        logic [7:0] d;
        logic [50:0] ys;
        logic [26:0] um, vm, n;
        logic [27:0] sm;
        logic [9:0] e;
        logic [4:0] lz;
        logic [23:0] mr;
        logic pn, qn, pi, qi;
        pn = p[30:23] == 8'hFF && p[22:0] != 0;
        qn = q[30:23] == 8'hFF && q[22:0] != 0;
        pi = p[30:23] == 8'hFF && p[22:0] == 0;
        qi = q[30:23] == 8'hFF && q[22:0] == 0;
        u  = q[30:0] > p[30:0] ? q : p;
        v  = q[30:0] > p[30:0] ? p : q;
        d  = u[30:23] - v[30:23];
        ys = {1'b1, v[22:0], 27'd0} >> (d > 8'd31 ? 8'd31 : d);
        vm = {ys[50:25], |ys[24:0]};
        um = {1'b1, u[22:0], 3'd0};
        sm = u[31] == v[31] ? {1'b0, um} + {1'b0, vm} : {1'b0, um} - {1'b0, vm};
        lz = 5'd0;
        for (int i = 0; i < 27; i++) if (sm[i]) lz = 5'(26 - i);
        n  = sm[27] ? {sm[27:2], sm[1] | sm[0]} : sm[26:0] << lz;
        e  = sm[27] ? {2'b0, u[30:23]} + 10'd1 : {2'b0, u[30:23]} - {5'd0, lz};
        mr = {1'b0, n[25:3]} + {23'd0, n[2] & (n[1] | n[0] | n[3])};
        e  = e + {9'd0, mr[23]};
        return (pn || qn || (pi && qi && p[31] != q[31])) ? 32'h7FC00000 : pi ? p : qi ? q :
               (p[30:23] == 8'h00 && q[30:23] == 8'h00) ? {p[31] & q[31], 31'd0} :
               p[30:23] == 8'h00 ? q : q[30:23] == 8'h00 ? p : sm == 28'd0 ? 32'd0 :
               (e[9] || e == 10'd0) ? {u[31], 31'd0} : (e >= 10'd255) ? {u[31], 8'hFF, 23'd0} :
               {u[31], e[7:0], mr[22:0]};
    endfunction

    assign a_ack = st == GET;
    assign b_ack = st == GET;
    assign z_stb = st == PUT;

    always_comb begin
        st_n = st;
        st_n = st == GET ? (a_stb && b_stb ? CALC : GET) : st == CALC ? PUT : (z_ack ? GET : PUT);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= GET;
        else st <= st_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ra <= '0;
            rb <= '0;
            z  <= '0;
        end else begin
            if (st == GET && a_stb && b_stb) begin
                ra <= a;
                rb <= b;
            end
            if (st == CALC) z <= ADD ? fadd(ra, rb) : fmul(ra, rb);
        end
endmodule

module shape_aabb_engine #(
    parameter logic [31:0] MARGIN       = 32'h00000000,
    parameter bit          FLUSH_DENORM = 1'b1
) (
    input logic              clk,
    input logic              rst,
    shape_aabb_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RAD, AXIS_MUL, AXIS_RNG, AXIS_MIN, AXIS_MAX, DONE} state_t;
    state_t state, nxt;
    logic [1:0]  axis;
    logic        m, mul_iss, add_iss;
    logic [31:0] px, py, pz, lz_r, rx, ry, rz, reff, p, rng;
    logic [31:0] bb [6];
    logic [31:0] pos, rsel, h, rng_eff, add_a, add_b, add_z, mul_z;
    logic        fp_rst, mul_stb, add_stb, mul_aa, mul_ba, add_aa, add_ba, mul_zs, add_zs, mul_done, add_done;

    assign fp_rst   = ~rst;
    assign pos      = axis == 2'd0 ? px : axis == 2'd1 ? py : pz;
    assign rsel     = axis == 2'd0 ? rx : axis == 2'd1 ? ry : rz;
    // Half of |p|: exponent decrement, keeping Inf/NaN and zero intact.
    assign h        = p[30:23] == 8'h00 ? 32'd0 : p[30:23] == 8'hFF ? {1'b0, p[30:0]} :
                      p[30:23] == 8'h01 ? (FLUSH_DENORM ? 32'd0 : {9'd0, 1'b1, p[22:1]}) :
                      {1'b0, p[30:23] - 8'd1, p[22:0]};
    assign rng_eff  = m ? reff : rng;
    assign add_a    = state == RAD ? reff : state == AXIS_RNG ? h : pos;
    assign add_b    = state == RAD ? MARGIN : state == AXIS_RNG ? reff :
                      state == AXIS_MIN ? {~rng_eff[31], rng_eff[30:0]} : rng_eff;
    assign mul_stb  = state == AXIS_MUL && !mul_iss;
    assign add_stb  = (state == RAD || state == AXIS_RNG || state == AXIS_MIN || state == AXIS_MAX) && !add_iss;
    assign mul_done = state == AXIS_MUL && mul_iss && mul_zs;
    assign add_done = state != AXIS_MUL && state != IDLE && state != DONE && add_iss && add_zs;

    fp_unit #(.ADD(1'b0)) u_mul (
        .clk(clk), .rst(fp_rst), .a(rsel), .a_stb(mul_stb), .a_ack(mul_aa), .b(lz_r), .b_stb(mul_stb),
        .b_ack(mul_ba), .z(mul_z), .z_stb(mul_zs), .z_ack(mul_done)
    );
    fp_unit #(.ADD(1'b1)) u_add (
        .clk(clk), .rst(fp_rst), .a(add_a), .a_stb(add_stb), .a_ack(add_aa), .b(add_b), .b_stb(add_stb),
        .b_ack(add_ba), .z(add_z), .z_stb(add_zs), .z_ack(add_done)
    );

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.aabb0     = bb[0];
    assign bus.aabb1     = bb[1];
    assign bus.aabb2     = bb[2];
    assign bus.aabb3     = bb[3];
    assign bus.aabb4     = bb[4];
    assign bus.aabb5     = bb[5];
    assign bus.invalid   = state == DONE && (&bb[0][30:23] || &bb[1][30:23] || &bb[2][30:23] ||
                                             &bb[3][30:23] || &bb[4][30:23] || &bb[5][30:23]);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (bus.in_valid) nxt = MARGIN == 32'h0 ? (bus.mode ? AXIS_MIN : AXIS_MUL) : RAD;
            RAD:      if (add_done) nxt = m ? AXIS_MIN : AXIS_MUL;
            AXIS_MUL: if (mul_done) nxt = AXIS_RNG;
            AXIS_RNG: if (add_done) nxt = AXIS_MIN;
            AXIS_MIN: if (add_done) nxt = AXIS_MAX;
            AXIS_MAX: if (add_done) nxt = axis == 2'd2 ? DONE : (m ? AXIS_MIN : AXIS_MUL);
            DONE:     if (bus.out_ready) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            axis    <= '0;
            m       <= 1'b0;
            mul_iss <= 1'b0;
            add_iss <= 1'b0;
            {px, py, pz, lz_r, rx, ry, rz, reff, p, rng} <= '0;
            bb      <= '{default: '0};
        end else begin
            if (state == IDLE && bus.in_valid) begin
                m    <= bus.mode;
                px   <= bus.x;
                py   <= bus.y;
                pz   <= bus.z;
                lz_r <= bus.lz;
                rx   <= bus.r_x;
                ry   <= bus.r_y;
                rz   <= bus.r_z;
                reff <= bus.radius;
                axis <= 2'd0;
            end
            if (mul_done) mul_iss <= 1'b0;
            else if (mul_stb && mul_aa && mul_ba) mul_iss <= 1'b1;
            if (add_done) add_iss <= 1'b0;
            else if (add_stb && add_aa && add_ba) add_iss <= 1'b1;
            if (mul_done) p <= mul_z;
            if (add_done && state == RAD) reff <= add_z;
            if (add_done && state == AXIS_RNG) rng <= add_z;
            if (add_done && state == AXIS_MIN) bb[{axis, 1'b0}] <= add_z;
            if (add_done && state == AXIS_MAX) begin
                bb[{axis, 1'b1}] <= add_z;
                axis <= axis == 2'd2 ? 2'd0 : axis + 2'd1;
            end
        end
endmodule

// File: tb/tb_shape_aabb_engine.sv
// tb_shape_aabb_engine: scoreboard bench with directed and random capsule/sphere jobs against a real-arithmetic model.
module tb_shape_aabb_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rnd_rdy = 1'b0;
    always #5 clk = ~clk;

    shape_aabb_engine_if ifc();
    shape_aabb_engine dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct packed {
        logic [5:0][31:0] a;
        logic             inv;
        logic             full;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
        e = {3'd0, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(v);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rv(input int lo, input int hi);
        int k;
        k = int'($urandom_range(hi - lo)) + lo;
        return r2f(k / 8.0);
    endfunction

    // Box half-extent per axis: radius, plus half the projected capsule length for capsules.
    function automatic logic [5:0][31:0] model(input logic md, input logic [31:0] px, py, pz, l, rd, rx, ry, rz);
        logic [5:0][31:0] o;
        real pos[3];
        real rr[3];
        real ext, pr;
        pos[0] = f2r(px); pos[1] = f2r(py); pos[2] = f2r(pz);
        rr[0] = f2r(rx); rr[1] = f2r(ry); rr[2] = f2r(rz);
        for (int i = 0; i < 3; i++) begin
            ext = f2r(rd);
            if (!md) begin
                pr  = rr[i] * f2r(l);
                ext = (pr < 0.0 ? -pr : pr) * 0.5 + ext;
            end
            o[2*i]   = r2f(pos[i] + (-ext));
            o[2*i+1] = r2f(pos[i] + ext);
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [5:0][31:0] a, input logic inv, input logic full);
        exp_t e;
        e.a = a; e.inv = inv; e.full = full;
        sb.push_back(e);
    endtask

    task automatic send(input logic md, input logic [31:0] px, py, pz, l, rd, rx, ry, rz);
        int n = 0;
        ifc.mode = md; ifc.x = px; ifc.y = py; ifc.z = pz; ifc.lz = l; ifc.radius = rd;
        ifc.r_x = rx; ifc.r_y = ry; ifc.r_z = rz; ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (!ifc.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk); n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst && ifc.out_valid && ifc.out_ready) begin
            logic [5:0][31:0] act;
            exp_t e;
            act = {ifc.aabb5, ifc.aabb4, ifc.aabb3, ifc.aabb2, ifc.aabb1, ifc.aabb0};
            if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                if (e.full) for (int k = 0; k < 6; k++) chk($sformatf("aabb%0d", k), act[k], e.a[k]);
                else chk("aabb5_exp", {24'd0, act[5][30:23]}, 32'hFF);
                chk("invalid", {31'd0, ifc.invalid}, {31'd0, e.inv});
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) ifc.out_ready = 1'($urandom_range(1));
    end

    localparam logic [5:0][31:0] T1 = {32'h3FC00000, 32'hBFC00000, 32'h3F000000, 32'hBF000000, 32'h3F000000, 32'hBF000000};
    localparam logic [5:0][31:0] T3 = {32'h3FA00000, 32'h3F400000, 32'h3FA00000, 32'h3F400000, 32'h3FA00000, 32'h3F400000};

    initial begin
        logic [5:0][31:0] snap, cur;
        logic [31:0] v[9];
        int n;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.mode = 1'b0;
        {ifc.x, ifc.y, ifc.z, ifc.lz, ifc.radius, ifc.r_x, ifc.r_y, ifc.r_z} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_invalid", {31'd0, ifc.invalid}, 32'd0);
        chk("rst_aabb0", ifc.aabb0, 32'd0);
        chk("rst_aabb5", ifc.aabb5, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        push(T1, 1'b0, 1'b1);
        send(1'b0, 0, 0, 0, 32'h40000000, 32'h3F000000, 0, 0, 32'h3F800000);
        drain();
        push(model(1'b0, 32'h40400000, 0, 0, 32'h40000000, 32'h3F000000, 32'hBF800000, 0, 0), 1'b0, 1'b1);
        send(1'b0, 32'h40400000, 0, 0, 32'h40000000, 32'h3F000000, 32'hBF800000, 0, 0);
        drain();
        push(T3, 1'b0, 1'b1);
        send(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h3E800000, 32'h12345678, 32'h7F800000, 0);
        drain();
        ifc.out_ready = 1'b0;
        push(model(1'b0, 32'h3F800000, 32'hC0000000, 32'h40A00000, 32'h40800000, 32'h3F800000, 32'h3F000000, 32'hBF400000, 32'h3E800000), 1'b0, 1'b1);
        send(1'b0, 32'h3F800000, 32'hC0000000, 32'h40A00000, 32'h40800000, 32'h3F800000, 32'h3F000000, 32'hBF400000, 32'h3E800000);
        n = 0;
        while (!ifc.out_valid && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        snap = {ifc.aabb5, ifc.aabb4, ifc.aabb3, ifc.aabb2, ifc.aabb1, ifc.aabb0};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ifc.in_valid = 1'(i % 2 == 0);
            ifc.x = rv(-64, 64); ifc.mode = 1'($urandom_range(1));
            @(negedge clk);
            cur = {ifc.aabb5, ifc.aabb4, ifc.aabb3, ifc.aabb2, ifc.aabb1, ifc.aabb0};
            chk("bp_stable", {31'd0, cur == snap}, 32'd1);
            chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, ifc.out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_idle_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("bp_no_second_job", {31'd0, ifc.out_valid}, 32'd0);
        send(1'b0, 0, 0, 0, 32'h40000000, 32'h3F000000, 0, 0, 32'h3F800000);
        n = 0;
        while (!(dut.axis == 2'd2 && dut.mul_iss) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_z_mul", {31'd0, dut.axis == 2'd2 && dut.mul_iss}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        push(T1, 1'b0, 1'b1);
        send(1'b0, 0, 0, 0, 32'h40000000, 32'h3F000000, 0, 0, 32'h3F800000);
        drain();
        push('0, 1'b1, 1'b0);
        send(1'b0, 0, 0, 0, 32'h7F800000, 32'h3F000000, 0, 0, 32'h3F800000);
        drain();
        rnd_rdy = 1'b1;
        for (int j = 0; j < 40; j++) begin
            logic md;
            md = 1'($urandom_range(1));
            v[0] = rv(-64, 64); v[1] = rv(-64, 64); v[2] = rv(-64, 64); v[3] = rv(-64, 64);
            v[4] = rv(0, 64); v[5] = rv(-8, 8); v[6] = rv(-8, 8); v[7] = rv(-8, 8);
            push(model(md, v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]), 1'b0, 1'b1);
            send(md, v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
        end
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        ifc.out_ready = 1'b1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
